// File: rtl/fetch_seq_unit.sv
// rtl/fetch_seq_unit.sv - Multi-cycle Y86-64 fetch stage reading a byte-wide instruction memory.
module fetch_seq_unit #(
  parameter int IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        imem_error,
  output logic        instr_error,
  output logic        halt,
  output logic        nop
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_SIZE);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t      state;
  logic [63:0] pc;
  logic [3:0]  k;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7: ifun_ok = (fn <= 4'd6);
      4'h6:       ifun_ok = (fn <= 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF: ifun_ok = 1'b0;
      default:    ifun_ok = (fn == 4'd0);
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    has_regs = ((ic >= 4'h2) && (ic <= 4'h6)) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  logic [3:0]  cur_len;
  logic        byte0_ok;
  logic        is_last;
  logic [2:0]  c_idx;
  logic [63:0] next_addr;

  // Length is known from byte 0 onward; on byte 0 it comes straight off the bus.
  assign cur_len   = instr_len((k == 4'd0) ? mem_rdata[7:4] : icode);
  assign byte0_ok  = ifun_ok(mem_rdata[7:4], mem_rdata[3:0]);
  assign is_last   = (k == 4'd0) ? (!byte0_ok || cur_len == 4'd1) : (k + 4'd1 == cur_len);
  assign c_idx     = k[2:0] - (has_regs(icode) ? 3'd2 : 3'd1);
  assign next_addr = mem_addr + 64'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      k           <= '0;
      pc_ready    <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      icode       <= '0;
      ifun        <= '0;
      rA          <= '0;
      rB          <= '0;
      valC        <= '0;
      valP        <= '0;
      imem_error  <= 1'b0;
      instr_error <= 1'b0;
      halt        <= 1'b0;
      nop         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_valid && pc_ready) begin
            pc          <= pc_in;
            k           <= '0;
            pc_ready    <= 1'b0;
            mem_addr    <= pc_in;
            mem_req     <= (pc_in < IMEM_LIMIT);
            icode       <= '0;
            ifun        <= '0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= '0;
            valP        <= '0;
            imem_error  <= 1'b0;
            instr_error <= 1'b0;
            halt        <= 1'b0;
            nop         <= 1'b0;
            state       <= FETCH;
          end else begin
            pc_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (!mem_req) begin
            // Next byte lies beyond the memory: stop without requesting it.
            imem_error <= 1'b1;
            valP       <= pc;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (mem_ack) begin
            if (mem_err) begin
              imem_error <= 1'b1;
              valP       <= pc;
              mem_req    <= 1'b0;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              if (k == 4'd0) begin
                icode <= mem_rdata[7:4];
                ifun  <= mem_rdata[3:0];
                if (!byte0_ok) begin
                  instr_error <= 1'b1;
                end else if (cur_len == 4'd1) begin
                  halt <= (mem_rdata[7:4] == 4'h0);
                  nop  <= (mem_rdata[7:4] == 4'h1);
                end
              end else if (k == 4'd1 && has_regs(icode)) begin
                rA <= mem_rdata[7:4];
                rB <= mem_rdata[3:0];
              end else begin
                valC[{c_idx, 3'b000} +: 8] <= mem_rdata;
              end
              if (is_last) begin
                valP      <= pc + {60'd0, k} + 64'd1;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                k        <= k + 4'd1;
                mem_addr <= next_addr;
                mem_req  <= (next_addr < IMEM_LIMIT);
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq_unit.sv
// tb/tb_fetch_seq_unit.sv - Table-driven directed bench for fetch_seq_unit.
module tb_fetch_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        imem_error, instr_error, halt, nop;

  fetch_seq_unit #(.IMEM_SIZE(1024)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .imem_error(imem_error), .instr_error(instr_error), .halt(halt), .nop(nop)
  );

  always #5 clk = ~clk;

  // Byte memory with programmable wait states and error address.
  logic [7:0]  mem [0:1023];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        err_on = 1'b0;
  logic [63:0] err_addr = '0;
  logic        oob_seen = 1'b0;

  assign mem_rdata = mem[mem_addr[9:0]];
  assign mem_ack   = mem_req && (wcnt >= wait_cycles);
  assign mem_err   = mem_req && err_on && (mem_addr == err_addr);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_req && mem_addr >= 64'd1024) oob_seen <= 1'b1;
  end

  typedef struct {
    logic [63:0] pc;
    logic [79:0] code;
    int          len;
    logic        err_on;
    logic [63:0] err_addr;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        ierr, xerr, hlt, np;
    int          cyc;
  } vec_t;

  vec_t vecs [16];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic issue(input logic [63:0] pc);
    int n = 0;
    @(negedge clk);
    while (!pc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pc_ready_idle", {63'd0, pc_ready}, 64'd1);
    pc_in    = pc;
    pc_valid = 1'b1;
    @(posedge clk);
    #1 pc_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!out_valid && cyc < 200);
    check("out_valid_rise", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("pc_ready_after", {63'd0, pc_ready}, 64'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc;
    logic [63:0] a;
    v = vecs[i];
    for (int j = 0; j < v.len; j++) begin
      a = v.pc + 64'(j);
      if (a < 64'd1024) mem[a[9:0]] = v.code[8*j +: 8];
    end
    err_on   = v.err_on;
    err_addr = v.err_addr;
    issue(v.pc);
    wait_done(cyc);
    check($sformatf("v%0d.cycles", i), 64'(cyc), 64'(v.cyc));
    check($sformatf("v%0d.icode", i), {60'd0, icode}, {60'd0, v.icode});
    check($sformatf("v%0d.ifun", i), {60'd0, ifun}, {60'd0, v.ifun});
    check($sformatf("v%0d.rA", i), {60'd0, rA}, {60'd0, v.ra});
    check($sformatf("v%0d.rB", i), {60'd0, rB}, {60'd0, v.rb});
    check($sformatf("v%0d.valC", i), valC, v.valc);
    check($sformatf("v%0d.valP", i), valP, v.valp);
    check($sformatf("v%0d.flags", i), {60'd0, imem_error, instr_error, halt, nop},
          {60'd0, v.ierr, v.xerr, v.hlt, v.np});
    err_on = 1'b0;
    release_out();
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    pc_in     = '0;
    pc_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    //        pc       code (byte0 in LSB)           len err  eaddr  ic    fn    rA    rB    valC                     valP     ie xe h  n  cyc
    vecs[0]  = '{64'h0,   80'h0102030405060708F430, 10, 1'b0, 64'h0, 4'h3, 4'h0, 4'hF, 4'h4, 64'h0102030405060708, 64'd10,  1'b0,1'b0,1'b0,1'b0, 10};
    vecs[1]  = '{64'h20,  80'h00,                    1, 1'b0, 64'h0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21,   1'b0,1'b0,1'b1,1'b0, 1};
    vecs[2]  = '{64'h10,  80'h1262,                  2, 1'b0, 64'h0, 4'h6, 4'h2, 4'h1, 4'h2, 64'h0, 64'h12,   1'b0,1'b0,1'b0,1'b0, 2};
    vecs[3]  = '{64'h10,  80'h64,                    1, 1'b0, 64'h0, 4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h11,   1'b0,1'b1,1'b0,1'b0, 1};
    vecs[4]  = '{64'h30,  80'h10,                    1, 1'b0, 64'h0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31,   1'b0,1'b0,1'b0,1'b1, 1};
    vecs[5]  = '{64'h40,  80'h112233445566778874,    9, 1'b0, 64'h0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h1122334455667788, 64'h49, 1'b0,1'b0,1'b0,1'b0, 9};
    vecs[6]  = '{64'h50,  80'h2FA0,                  2, 1'b0, 64'h0, 4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 64'h52,   1'b0,1'b0,1'b0,1'b0, 2};
    vecs[7]  = '{64'h60,  80'hC0,                    1, 1'b0, 64'h0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61,   1'b0,1'b1,1'b0,1'b0, 1};
    vecs[8]  = '{64'h68,  80'h90,                    1, 1'b0, 64'h0, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h69,   1'b0,1'b0,1'b0,1'b0, 1};
    vecs[9]  = '{64'h6C,  80'h01,                    1, 1'b0, 64'h0, 4'h0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h6D,   1'b0,1'b1,1'b0,1'b0, 1};
    vecs[10] = '{64'h80,  80'h11223344556677881540, 10, 1'b0, 64'h0, 4'h4, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'h8A, 1'b0,1'b0,1'b0,1'b0, 10};
    vecs[11] = '{64'd1019,80'h0403020170,            5, 1'b0, 64'h0, 4'h7, 4'h0, 4'hF, 4'hF, 64'h04030201, 64'd1019, 1'b1,1'b0,1'b0,1'b0, 6};
    vecs[12] = '{64'd2000,80'h0,                     0, 1'b0, 64'h0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd2000, 1'b1,1'b0,1'b0,1'b0, 1};
    vecs[13] = '{64'h70,  80'h0102030405060708F430, 10, 1'b1, 64'h71, 4'h3, 4'h0, 4'hF, 4'hF, 64'h0, 64'h70,  1'b1,1'b0,1'b0,1'b0, 2};
    vecs[14] = '{64'hA0,  80'h3426,                  2, 1'b0, 64'h0, 4'h2, 4'h6, 4'h3, 4'h4, 64'h0, 64'hA2,   1'b0,1'b0,1'b0,1'b0, 2};
    vecs[15] = '{64'hA8,  80'h77,                    1, 1'b0, 64'h0, 4'h7, 4'h7, 4'hF, 4'hF, 64'h0, 64'hA9,   1'b0,1'b1,1'b0,1'b0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst.pc_ready", {63'd0, pc_ready}, 64'd0);
    check("rst.outs", {58'd0, mem_req, out_valid, imem_error, instr_error, halt, nop}, 64'd0);
    check("rst.rArB", {56'd0, rA, rB}, 64'd0);
    check("rst.valP", valP, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("rst.pc_ready_rise", {63'd0, pc_ready}, 64'd1);

    for (int i = 0; i < 16; i++) run_vec(i);
    check("oob_mem_req", {63'd0, oob_seen}, 64'd0);

    // call with two wait states per byte, then a three-cycle output stall
    for (int j = 0; j < 9; j++) mem[10'h100 + 10'(j)] = (j == 0) ? 8'h80 : 8'(8'hEF - 8'(j - 1) * 8'h22);
    wait_cycles = 2;
    issue(64'h100);
    wait_done(cyc);
    check("call.cycles", 64'(cyc), 64'd27);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.valid", s), {62'd0, out_valid, pc_ready}, 64'd2);
      check($sformatf("stall%0d.valC", s), valC, 64'h0123456789ABCDEF);
      check($sformatf("stall%0d.fields", s), {48'd0, icode, ifun, rA, rB}, 64'h80FF);
      check($sformatf("stall%0d.valP", s), valP, 64'h109);
    end
    release_out();
    wait_cycles = 0;

    // reset while byte 4 of an rmmovq is on the bus
    for (int j = 0; j < 10; j++) mem[10'h200 + 10'(j)] = (j == 0) ? 8'h40 : (j == 1) ? 8'h35 : 8'(j);
    issue(64'h200);
    repeat (4) @(posedge clk);
    #1 check("rst6.addr", mem_addr, 64'h204);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst6.after", {61'd0, mem_req, pc_ready, out_valid}, 64'd0);
    @(posedge clk);
    #1 check("rst6.idle", {63'd0, pc_ready}, 64'd1);
    run_vec(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
